// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and helpers.
//   RF_AW    - register address width
//   RF_DW    - register data width
//   RF_DEPTH - number of architectural registers
//   clog2()  - index width for a requester count (never less than 1 bit)
package rf_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;

    // A single requester still needs a 1-bit index so the ports stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin grant.
//   req   in  NREQ  request vector
//   last  in  IW    index of the most recent winner
//   en    in  1     grant enable (slot free and out of reset)
//   grant out NREQ  one-hot grant, zero when disabled or nobody requests
//   idx   out IW    winner index; with no grant, (last+1) mod NREQ
module rr_grant
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic found;
    int   cand;

    // Scan last+1, last+2, ... wrapping at NREQ; first valid requester wins.
    // The default index is the first slot of the scan so the address mux
    // stays deterministic when nothing is granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = 0;
        idx   = IW'((int'(last) + 1) % NREQ);
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = IW'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: shares the register-file read port among NREQ requesters
// with round-robin priority and a one-entry registered response slot.
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_addr   per-requester request and packed addresses
//   req_ready            one-hot grant (acceptance = valid & ready)
//   rf_raddr/rf_rdata    address to / combinational data from the selector
//   rsp_valid/id/data    response slot contents
//   rsp_ready            downstream consumes the slot
// Optional build macro RF_READ_ARB_BYPASS_EN adds wb_we/wb_waddr/wb_wdata,
// forwarding same-cycle writeback data for non-zero matching addresses.
module rf_read_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]   req_ready,
    output logic [AW-1:0]     rf_raddr,
    input  logic [DW-1:0]     rf_rdata,
`ifdef RF_READ_ARB_BYPASS_EN
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_waddr,
    input  logic [DW-1:0]     wb_wdata,
`endif
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [DW-1:0]     rsp_data,
    input  logic              rsp_ready
);

    localparam int IW = clog2(NREQ);

    logic [IW-1:0]   last;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] grant;
    logic            slot_free;
    logic            accept;
    logic [DW-1:0]   sel_data;
    logic [AW-1:0]   addr_arr [NREQ];

    // Slot can take new data if empty or drained this very edge. Gating with
    // rst_n keeps grants off while reset is asserted.
    assign slot_free = !rsp_valid || rsp_ready;

    rr_grant #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_grant (
        .req   (req_valid),
        .last  (last),
        .en    (slot_free && rst_n),
        .grant (grant),
        .idx   (win_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
        end
    end

    // With no grant win_idx already points at (last+1) mod NREQ.
    assign rf_raddr = addr_arr[win_idx];

`ifdef RF_READ_ARB_BYPASS_EN
    // Writeback in the same cycle is newer than the array contents; r0 is
    // hardwired to zero and must never pick up forwarded data.
    always_comb begin
        sel_data = rf_rdata;
        if (wb_we && (wb_waddr == rf_raddr) && (wb_waddr != '0)) begin
            sel_data = wb_wdata;
        end
    end
`else
    assign sel_data = rf_rdata;
`endif

    // Refill takes precedence over drain so back-to-back reads keep
    // rsp_valid high; a drain without refill leaves id/data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            last      <= IW'(NREQ - 1);
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_id    <= 3'(win_idx);
            rsp_data  <= sel_data;
            last      <= win_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
